// File: rtl/lcd_byte_stream_tx_if.sv
// Byte-stream and I2C-writer handshake bundle for lcd_byte_stream_tx.
// master: upstream producer plus the downstream I2C writer's acknowledge side.
// slave : the transmitter itself.
interface lcd_byte_stream_tx_if;
    logic       wr_en;
    logic       wr_mode;
    logic [7:0] wr_data;
    logic       bl_on;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       byte_done;
    logic       i2c_req;
    logic [7:0] i2c_byte;
    logic       i2c_done;

    modport master (
        output wr_en, wr_mode, wr_data, bl_on, i2c_done,
        input  full, empty, ovf, busy, byte_done, i2c_req, i2c_byte
    );

    modport slave (
        input  wr_en, wr_mode, wr_data, bl_on, i2c_done,
        output full, empty, ovf, busy, byte_done, i2c_req, i2c_byte
    );
endinterface

// File: rtl/lcd_byte_stream_tx.sv
// Buffered HD44780 byte sender for a PCF8574 I2C backpack.
// Bytes tagged command/character are queued in a small FIFO, split into four
// 4-bit-mode frames ({nibble, BL, EN, RW=0, RS}) and handed one at a time to a
// single-byte I2C writer. After each byte a settle delay is inserted (long for
// clear/home commands 0x01..0x03).
// Optional feature macro: LCD_TX_SETTLE_DELAY_EN. When undefined the DELAY state
// lasts a single cycle and no delay counter is built.
module lcd_byte_stream_tx #(
    parameter int DEPTH     = 4,
    parameter int SHORT_DLY = 2000,
    parameter int LONG_DLY  = 80000,
    parameter int CNT_W     = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_byte_stream_tx_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DELAY
    } state_e;

    // Elaboration-time guards on the configuration.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lcd_byte_stream_tx: DEPTH must be a power of two in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32 || SHORT_DLY < 0 || LONG_DLY < 0 ||
        longint'(SHORT_DLY) >= (longint'(1) << CNT_W) ||
        longint'(LONG_DLY) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("lcd_byte_stream_tx: CNT_W too small for SHORT_DLY/LONG_DLY");
    end

    // ---------------------------------------------------------------- FIFO
    logic [8:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic [OCC_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             ovf_q;
    logic             pop;
    logic             push_ok;

    // ---------------------------------------------------------------- FSM
    state_e      state_q;
    logic [8:0]  entry_q;      // {mode, data} of the byte in flight
    logic        bl_q;
    logic [1:0]  k_q;          // frame index 0..3
    logic        busy_q;
    logic        byte_done_q;
    logic        i2c_req_q;
    logic [7:0]  i2c_byte_q;

    assign pop     = (state_q == S_IDLE) && !empty_q;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok = bus.wr_en && (!full_q || pop);

    // Next occupancy from the push/pop pair.
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Entry storage; written on every accepted push.
    // NOTE: the storage array is deliberately not reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {bus.wr_mode, bus.wr_data};
        end
    end

    // FIFO pointers, registered full/empty flags and the sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == OCC_W'(DEPTH));
            empty_q <= (count_d == '0);
            if (bus.wr_en && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // PCF8574 frame k of a byte: high nibble for k = 0,1, low nibble for k = 2,3;
    // EN is high on even k and low on odd k; RW is always 0.
    function automatic logic [7:0] lcd_frame(input logic [8:0] entry, input logic bl,
                                             input logic [1:0] k);
        logic [3:0] nib;
        nib = k[1] ? entry[3:0] : entry[7:4];
        return {nib, bl, ~k[0], 1'b0, entry[8]};
    endfunction

`ifdef LCD_TX_SETTLE_DELAY_EN
    logic [CNT_W-1:0] cnt_q;
    logic             long_cmd;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    assign long_cmd = !entry_q[8] && (entry_q[7:2] == 6'd0) && (entry_q[1:0] != 2'd0);
`endif

    // Byte sequencer: pop, frame out four nibble strobes, then settle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            entry_q     <= '0;
            bl_q        <= 1'b0;
            k_q         <= 2'd0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            i2c_req_q   <= 1'b0;
            i2c_byte_q  <= 8'h00;
`ifdef LCD_TX_SETTLE_DELAY_EN
            cnt_q       <= '0;
`endif
        end else begin
            byte_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The head entry is captured here because the read pointer
                    // moves past it on this same edge.
                    if (!empty_q) begin
                        entry_q <= mem_q[rd_ptr_q];
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bl_q    <= bus.bl_on;
                    k_q     <= 2'd0;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    i2c_byte_q <= lcd_frame(entry_q, bl_q, k_q);
                    i2c_req_q  <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i2c_done) begin
                        i2c_req_q <= 1'b0;
                        if (k_q == 2'd3) begin
`ifdef LCD_TX_SETTLE_DELAY_EN
                            cnt_q <= long_cmd ? CNT_W'(LONG_DLY) : CNT_W'(SHORT_DLY);
`endif
                            state_q <= S_DELAY;
                        end else begin
                            k_q     <= k_q + 2'd1;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    state_q <= S_SEND;
                end
                S_DELAY: begin
`ifdef LCD_TX_SETTLE_DELAY_EN
                    if (cnt_q == '0) begin
                        byte_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`else
                    byte_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.byte_done = byte_done_q;
    assign bus.i2c_req   = i2c_req_q;
    assign bus.i2c_byte  = i2c_byte_q;
endmodule

// File: tb/tb_lcd_byte_stream_tx.sv
// Self-checking bench for lcd_byte_stream_tx: an I2C writer model acknowledges
// frames, every frame and byte_done pulse is logged with its clock edge index,
// and expectations come from the nibble/strobe rules and delay rules directly.
module tb_lcd_byte_stream_tx;
    localparam int DEPTH     = 4;
    localparam int SHORT_DLY = 20;
    localparam int LONG_DLY  = 500;
    localparam int CNT_W     = 17;

    logic clk = 1'b0;
    logic rst;

    lcd_byte_stream_tx_if bus ();

    lcd_byte_stream_tx #(
        .DEPTH    (DEPTH),
        .SHORT_DLY(SHORT_DLY),
        .LONG_DLY (LONG_DLY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;        // number of rising edges so far

    int ack_lat = 10;      // negedges with req high before the writer acks
    bit ack_en  = 1'b1;

    logic [7:0] frames[$];  // frames in order of i2c_req rising
    int rise_cyc[$];        // edge after which each frame's req went high
    int done_cyc[$];        // edge that sampled each i2c_done pulse
    int bd_cyc[$];          // edge after which each byte_done pulse appeared

    int   hold;
    bit   done_sent;
    logic req_prev;

    always @(posedge clk) cyc++;

    // I2C writer model and bus monitor, sampling away from the rising edge.
    always @(negedge clk) begin
        bus.i2c_done = 1'b0;
        if (!rst) begin
            req_prev  = 1'b0;
            hold      = 0;
            done_sent = 1'b0;
        end else begin
            if (bus.i2c_req && !req_prev) begin
                frames.push_back(bus.i2c_byte);
                rise_cyc.push_back(cyc);
                hold = 0;
            end
            if (bus.i2c_req && ack_en && !done_sent) begin
                hold++;
                if (hold >= ack_lat) begin
                    bus.i2c_done = 1'b1;
                    done_cyc.push_back(cyc + 1);
                    done_sent = 1'b1;
                end
            end
            if (!bus.i2c_req) done_sent = 1'b0;
            if (bus.byte_done) bd_cyc.push_back(cyc);
            req_prev = bus.i2c_req;
        end
    end

    // Reference: frame k of a byte, from the nibble / strobe rules.
    function automatic logic [7:0] exp_frame(input bit mode, input int data, input bit bl,
                                             input int k);
        int nib;
        nib = (k < 2) ? (data / 16) : (data % 16);
        return 8'(nib * 16 + (bl ? 8 : 0) + ((k % 2 == 0) ? 4 : 0) + (mode ? 1 : 0));
    endfunction

    // Reference: edges from the edge sampling the 4th i2c_done to byte_done
    // (the settle state counts the loaded value down to zero, one extra edge).
    function automatic int exp_gap(input bit mode, input int data);
`ifdef LCD_TX_SETTLE_DELAY_EN
        return ((!mode && data >= 1 && data <= 3) ? LONG_DLY : SHORT_DLY) + 1;
`else
        return 1 + 0 * (mode ? data : 0);
`endif
    endfunction

    task automatic clear_log();
        frames.delete();
        rise_cyc.delete();
        done_cyc.delete();
        bd_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit mode, input int data, output int edge_n);
        bus.wr_en   = 1'b1;
        bus.wr_mode = mode;
        bus.wr_data = 8'(data);
        edge_n      = cyc + 1;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (frames.size() < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (frames.size() < n) begin
            errors++;
            $display("FAIL %s_frame_timeout: %0d frames seen, required %0d", tag, frames.size(), n);
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (bd_cyc.size() < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (bd_cyc.size() < n) begin
            errors++;
            $display("FAIL %s_byte_timeout: %0d byte_done pulses, required %0d", tag, bd_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_mode = 1'b0;
        bus.wr_data = 8'h00;
        bus.bl_on   = 1'b0;
        idle(3);
        checks += 7;
        if (bus.full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b, required 0", bus.full); end
        if (bus.empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b, required 1", bus.empty); end
        if (bus.ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        if (bus.byte_done !== 1'b0) begin errors++; $display("FAIL reset_byte_done: got %b, required 0", bus.byte_done); end
        if (bus.i2c_req !== 1'b0)   begin errors++; $display("FAIL reset_i2c_req: got %b, required 0", bus.i2c_req); end
        if (bus.i2c_byte !== 8'h00) begin errors++; $display("FAIL reset_i2c_byte: got %02h, required 00", bus.i2c_byte); end
        rst = 1'b1;
        idle(2);
    endtask

    // Command 0x28 with backlight on, writer acking 10 cycles after each request.
    task automatic test_cmd28();
        int n;
        ack_lat    = 10;
        bus.bl_on  = 1'b1;
        clear_log();
        push(1'b0, 'h28, n);
        checks++;
        if (bus.empty !== 1'b0) begin errors++; $display("FAIL cmd28_empty_after_push: got %b, required 0", bus.empty); end
        wait_frames(1, 50, "cmd28");
        checks += 2;
        if (rise_cyc[0] !== n + 3) begin errors++; $display("FAIL cmd28_req_latency: req high after edge %0d, required %0d", rise_cyc[0], n + 3); end
        if (bus.busy !== 1'b1)     begin errors++; $display("FAIL cmd28_busy: got %b, required 1", bus.busy); end
        wait_bytes(1, 3000, "cmd28");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (frames[k] !== exp_frame(1'b0, 'h28, 1'b1, k)) begin
                errors++;
                $display("FAIL cmd28_frame%0d: got %02h, required %02h", k, frames[k], exp_frame(1'b0, 'h28, 1'b1, k));
            end
        end
        checks++;
        if (bd_cyc[0] - done_cyc[3] !== exp_gap(1'b0, 'h28)) begin
            errors++;
            $display("FAIL cmd28_delay: got %0d edges, required %0d", bd_cyc[0] - done_cyc[3], exp_gap(1'b0, 'h28));
        end
        idle(5);
        checks += 3;
        if (bd_cyc.size() !== 1) begin errors++; $display("FAIL cmd28_byte_done_count: got %0d, required 1", bd_cyc.size()); end
        if (bus.busy !== 1'b0)   begin errors++; $display("FAIL cmd28_busy_end: got %b, required 0", bus.busy); end
        if (frames.size() !== 4) begin errors++; $display("FAIL cmd28_frame_count: got %0d, required 4", frames.size()); end
    endtask

    // Character 0x41 with backlight off: RS set in every frame.
    task automatic test_data41();
        int n;
        bus.bl_on = 1'b0;
        clear_log();
        push(1'b1, 'h41, n);
        wait_bytes(1, 3000, "data41");
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (frames[k] !== exp_frame(1'b1, 'h41, 1'b0, k)) begin
                errors++;
                $display("FAIL data41_frame%0d: got %02h, required %02h", k, frames[k], exp_frame(1'b1, 'h41, 1'b0, k));
            end
            if (frames[k][0] !== 1'b1) begin
                errors++;
                $display("FAIL data41_rs%0d: got %b, required 1", k, frames[k][0]);
            end
        end
        idle(3);
    endtask

    // Long vs short settle selection, including its boundaries.
    task automatic test_delays();
        bit modes[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int datas[7] = '{'h01, 'h0C, 'h02, 'h03, 'h04, 'h00, 'h01};
        int n;
        bus.bl_on = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ack_lat = int'($urandom_range(1, 6));
            clear_log();
            push(modes[i], datas[i], n);
            wait_bytes(1, 1500, "delay");
            checks++;
            if (bd_cyc[0] - done_cyc[3] !== exp_gap(modes[i], datas[i])) begin
                errors++;
                $display("FAIL delay_mode%0d_data%02h: got %0d edges, required %0d",
                         modes[i], datas[i], bd_cyc[0] - done_cyc[3], exp_gap(modes[i], datas[i]));
            end
            idle(2);
        end
    endtask

    // Three bytes pushed on consecutive edges: each pops right after the previous byte_done.
    task automatic test_back_to_back();
        int mode_l[3];
        int data_l[3];
        int n0;
        int n;
        ack_lat   = 3;
        bus.bl_on = 1'b1;
        clear_log();
        for (int b = 0; b < 3; b++) begin
            mode_l[b] = int'($urandom_range(0, 1));
            data_l[b] = int'($urandom_range(4, 255));
            push(mode_l[b][0], data_l[b], n);
            if (b == 0) n0 = n;
        end
        wait_bytes(3, 3000, "b2b");
        checks++;
        if (rise_cyc[0] !== n0 + 3) begin errors++; $display("FAIL b2b_first_latency: got %0d, required %0d", rise_cyc[0], n0 + 3); end
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (frames[4 * b + k] !== exp_frame(mode_l[b][0], data_l[b], 1'b1, k)) begin
                    errors++;
                    $display("FAIL b2b_byte%0d_frame%0d: got %02h, required %02h", b, k,
                             frames[4 * b + k], exp_frame(mode_l[b][0], data_l[b], 1'b1, k));
                end
            end
            if (b > 0) begin
                checks++;
                if (rise_cyc[4 * b] !== bd_cyc[b - 1] + 3) begin
                    errors++;
                    $display("FAIL b2b_pop_gap%0d: next req after edge %0d, required %0d", b, rise_cyc[4 * b], bd_cyc[b - 1] + 3);
                end
            end
        end
        idle(3);
    endtask

    // Stall the writer mid-byte, then push six: four fit, two are dropped.
    task automatic test_overflow();
        int mode_l[6];
        int data_l[6];
        int n;
        int exp_mode[5];
        int exp_data[5];
        ack_en    = 1'b0;
        ack_lat   = 2;
        bus.bl_on = 1'b0;
        clear_log();
        push(1'b0, 'h28, n);
        exp_mode[0] = 0;
        exp_data[0] = 'h28;
        wait_frames(1, 50, "ovf");
        for (int i = 0; i < 6; i++) begin
            mode_l[i] = int'($urandom_range(0, 1));
            data_l[i] = int'($urandom_range(4, 255));
            push(mode_l[i][0], data_l[i], n);
            checks += 2;
            if (bus.full !== (i >= 3)) begin errors++; $display("FAIL ovf_full_after_push%0d: got %b, required %b", i + 1, bus.full, i >= 3); end
            if (bus.ovf !== (i >= 4))  begin errors++; $display("FAIL ovf_flag_after_push%0d: got %b, required %b", i + 1, bus.ovf, i >= 4); end
            if (i < 4) begin
                exp_mode[i + 1] = mode_l[i];
                exp_data[i + 1] = data_l[i];
            end
        end
        ack_en = 1'b1;
        wait_bytes(5, 4000, "ovf");
        idle(40);
        checks++;
        if (frames.size() !== 20) begin errors++; $display("FAIL ovf_frame_count: got %0d, required 20", frames.size()); end
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (frames[4 * b + k] !== exp_frame(exp_mode[b][0], exp_data[b], 1'b0, k)) begin
                    errors++;
                    $display("FAIL ovf_byte%0d_frame%0d: got %02h, required %02h", b, k,
                             frames[4 * b + k], exp_frame(exp_mode[b][0], exp_data[b], 1'b0, k));
                end
            end
        end
        checks += 3;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_end: got %b, required 1", bus.empty); end
        if (bus.full !== 1'b0)  begin errors++; $display("FAIL ovf_full_end: got %b, required 0", bus.full); end
        if (bus.ovf !== 1'b1)   begin errors++; $display("FAIL ovf_sticky: got %b, required 1", bus.ovf); end
    endtask

    // Reset during frame 3 with two entries queued abandons everything.
    task automatic test_reset_midframe();
        int n;
        ack_lat   = 10;
        bus.bl_on = 1'b1;
        clear_log();
        push(1'b1, 'h55, n);
        push(1'b1, 'h66, n);
        push(1'b0, 'h0C, n);
        wait_frames(3, 200, "midrst");
        rst = 1'b0;
        idle(1);
        checks += 6;
        if (bus.i2c_req !== 1'b0)   begin errors++; $display("FAIL midrst_i2c_req: got %b, required 0", bus.i2c_req); end
        if (bus.empty !== 1'b1)     begin errors++; $display("FAIL midrst_empty: got %b, required 1", bus.empty); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
        if (bus.ovf !== 1'b0)       begin errors++; $display("FAIL midrst_ovf: got %b, required 0", bus.ovf); end
        if (bus.i2c_byte !== 8'h00) begin errors++; $display("FAIL midrst_i2c_byte: got %02h, required 00", bus.i2c_byte); end
        if (bus.full !== 1'b0)      begin errors++; $display("FAIL midrst_full: got %b, required 0", bus.full); end
        rst = 1'b1;
        idle(80);
        checks += 2;
        if (frames.size() !== 3) begin errors++; $display("FAIL midrst_no_more_frames: got %0d, required 3", frames.size()); end
        if (bd_cyc.size() !== 0) begin errors++; $display("FAIL midrst_no_byte_done: got %0d, required 0", bd_cyc.size()); end
        clear_log();
        bus.bl_on = 1'b0;
        push(1'b1, 'h41, n);
        wait_bytes(1, 1500, "midrst_after");
        checks++;
        if (rise_cyc[0] !== n + 3) begin errors++; $display("FAIL midrst_after_latency: got %0d, required %0d", rise_cyc[0], n + 3); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (frames[k] !== exp_frame(1'b1, 'h41, 1'b0, k)) begin
                errors++;
                $display("FAIL midrst_after_frame%0d: got %02h, required %02h", k, frames[k], exp_frame(1'b1, 'h41, 1'b0, k));
            end
        end
        idle(3);
    endtask

    // Random bytes, backlight and writer latency, one byte at a time.
    task automatic test_random();
        int  n;
        bit  mode;
        int  data;
        bit  bl;
        for (int i = 0; i < 12; i++) begin
            ack_lat   = int'($urandom_range(1, 6));
            mode      = 1'($urandom_range(0, 1));
            data      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
            bl        = 1'($urandom_range(0, 1));
            bus.bl_on = bl;
            clear_log();
            push(mode, data, n);
            wait_bytes(1, 1500, "rand");
            checks += 2;
            if (rise_cyc[0] !== n + 3) begin errors++; $display("FAIL rand%0d_latency: got %0d, required %0d", i, rise_cyc[0], n + 3); end
            if (bd_cyc[0] - done_cyc[3] !== exp_gap(mode, data)) begin
                errors++;
                $display("FAIL rand%0d_delay: got %0d edges, required %0d", i, bd_cyc[0] - done_cyc[3], exp_gap(mode, data));
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (frames[k] !== exp_frame(mode, data, bl, k)) begin
                    errors++;
                    $display("FAIL rand%0d_frame%0d: got %02h, required %02h", i, k, frames[k], exp_frame(mode, data, bl, k));
                end
            end
            idle(2);
        end
    endtask

    initial begin
        test_reset();
        test_cmd28();
        test_data41();
        test_delays();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lcd_byte_stream_tx.md
# lcd_byte_stream_tx

Buffered, parametrised successor to the single-byte LCD command/character sender. It accepts a stream of tagged bytes (command or character) into a small FIFO. Each byte is split into four HD44780 4-bit-mode frames for the PCF8574 I2C backpack, and the frames are handed one at a time to the downstream single-byte I2C writer. Per-byte settle delays, including a long delay for clear/home commands, are inserted so the init and control sequencer no longer times the LCD itself.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- SHORT_DLY, 2000: clk cycles waited after each ordinary byte (40 us at 50 MHz); 0 = no wait.
- LONG_DLY, 80000: clk cycles waited after commands 0x01–0x03 (1.6 ms at 50 MHz).
- CNT_W, 17: delay counter width; must hold max(SHORT_DLY, LONG_DLY).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- wr_en  in  1  push request.
- wr_mode  in  1  0 = command (RS=0), 1 = character data (RS=1).
- wr_data  in  8  byte to send.
- bl_on  in  1  backlight bit, sampled per byte at LOAD.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- ovf  out  1  sticky: a push was dropped.
- busy  out  1  FSM not in IDLE.
- byte_done  out  1  one-cycle pulse when a byte (including its delay) completes.
- i2c_req  out  1  frame request to the I2C writer.
- i2c_byte  out  8  PCF8574 frame.
- i2c_done  in  1  one-cycle pulse from the I2C writer: frame sent.

## Operation

**Frame format:** [7:4] nibble, [3] BL, [2] EN, [1] RW = 0, [0] RS.

**Frame order per byte:**
1. hi | EN = 1
2. hi | EN = 0
3. lo | EN = 1
4. lo | EN = 0

For example, command 0x28 with BL = 1 gives 0x2C, 0x28, 0x8C, 0x88. Data 0x41 with BL = 1 gives 0x4D, 0x49, 0x1D, 0x19.

**FIFO:**
- Stores 9-bit entries {mode, data}.
- A push is accepted when !full, or when a pop occurs in the same cycle.
- Otherwise the push is dropped and ovf is set; ovf clears only on reset.

**FSM states:**
- IDLE: if !empty, pop the FIFO and go to LOAD.
- LOAD: latch the entry and bl_on; set frame index k = 0; go to SEND.
- SEND: drive i2c_byte = frame k and i2c_req = 1; go to WAIT.
- WAIT: hold i2c_req and i2c_byte until i2c_done. Then:
  - If k < 3: k++, go to GAP.
  - If k = 3: go to DELAY.
- GAP: i2c_req = 0 for one cycle; go to SEND.
- DELAY: i2c_req = 0. Load the counter with LONG_DLY if mode = 0 and data ∈ {0x01, 0x02, 0x03}, else SHORT_DLY. Count down. When it reaches 0, pulse byte_done and go to IDLE. If the loaded value is 0, finish in one cycle.

**Other rules:**
- i2c_done is ignored outside WAIT.
- bl_on changes take effect at the next byte.

**Reset** (rst = 0 at a clk edge), taking effect at that edge:
- FIFO emptied; state = IDLE.
- full = 0, empty = 1, ovf = 0, busy = 0, byte_done = 0, i2c_req = 0, i2c_byte = 0x00.
- A frame in flight is abandoned.

## Timing
- Push at edge N → entry visible (empty = 0) after N; IDLE pop at N+1; LOAD at N+2; i2c_req high after edge N+3.
- i2c_req drops on the edge following i2c_done, with at least one low cycle between frames.
- Byte time = 4 × (2 + I2C frame time) + delay + 2 cycles.
- Back-to-back bytes: IDLE pops the next entry in the cycle after byte_done.
- full = (count == DEPTH); empty = (count == 0); both are registered.

## Configuration
- Macro: LCD_TX_SETTLE_DELAY_EN.
  - Defined: the DELAY state behaves as described above.
  - Undefined: DELAY lasts exactly one cycle regardless of SHORT_DLY/LONG_DLY, byte_done pulses, and the counter logic is not synthesised. The upstream sequencer then owns LCD timing.

## Test plan
- Push cmd 0x28, bl_on = 1; I2C model acks 10 cycles after each req → frames 0x2C, 0x28, 0x8C, 0x88 in order; one byte_done after the 2000-cycle delay.
- Push data 0x41 with bl_on = 0 → 0x45, 0x41, 0x15, 0x11; RS = 1 in every frame.
- Push cmd 0x01, SHORT_DLY = 20, LONG_DLY = 500 → 500 cycles from the 4th i2c_done to byte_done; cmd 0x0C → 20 cycles.
- DEPTH = 4: push 6 bytes back-to-back while the FSM is stalled on i2c_done → full = 1 after 4 pushes, ovf = 1, only 4 bytes transmitted, in order.
- Assert rst = 0 during frame 3 of a byte with 2 entries queued → next cycle i2c_req = 0, empty = 1, busy = 0; no further frames; a new push is sent normally.
- Build without LCD_TX_SETTLE_DELAY_EN, cmd 0x01 → byte_done exactly one cycle after the DELAY entry.
